// File: rtl/dsp_param_bank.sv
`default_nettype none
//------------------------------------------------------------------------------
// dsp_param_bank : DSP-writable parameter bank, staged writes, atomic per-channel commit. Rev 1.0
//------------------------------------------------------------------------------
module dsp_param_bank #(
  parameter int                   DATA_W       = 16,
  parameter int                   DSP_ADR_W    = 16,
  parameter logic [DSP_ADR_W-1:0] BASE_ADDR    = 'h400A,
  parameter int                   NUM_CH       = 4,
  parameter int                   WORDS_PER_CH = 2,
  parameter logic [DATA_W-1:0]    RESET_VAL    = '0,
  parameter int                   WB_ADR_W     = 8
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 nCS,
  input  logic                 nWR,
  input  logic                 nRD,
  input  logic [DSP_ADR_W-1:0] dsp_adr,
  input  logic [DATA_W-1:0]    dsp_dat_i,
  output logic [DATA_W-1:0]    dsp_dat_o,
  output logic                 dsp_dat_oe,
  input  logic                 CYC_I,
  input  logic                 STB_I,
  input  logic                 WE_I,
  input  logic [WB_ADR_W-1:0]  ADR_I,
  output logic [31:0]          DAT_O,
  output logic                 ACK_O,
  output logic [NUM_CH-1:0]    upd,
  output logic [NUM_CH-1:0]    pending
);

  localparam int                   TOTAL   = NUM_CH * WORDS_PER_CH;
  localparam int                   IDX_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [DSP_ADR_W-1:0] TOTAL_D = DSP_ADR_W'(TOTAL);
  localparam logic [WB_ADR_W-1:0]  TOTAL_W = WB_ADR_W'(TOTAL);

  logic cs_meta, cs_s, cs_q;
  logic wr_meta, wr_s, wr_q;
  logic rd_meta, rd_s;

  logic [DSP_ADR_W-1:0] adr_l;
  logic [DATA_W-1:0]    dat_l;

  logic [DATA_W-1:0] staging  [TOTAL];
  logic [DATA_W-1:0] active   [TOTAL];
  logic [DATA_W-1:0] stg_next [TOTAL];
  logic [TOTAL-1:0]  mask, mask_set, mask_next;
  logic [NUM_CH-1:0] commit;

  logic [DSP_ADR_W-1:0] wr_off, rd_off;
  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic                 wr_hit, rd_hit;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      cs_meta <= 1'b1; cs_s <= 1'b1; cs_q <= 1'b1;
      wr_meta <= 1'b1; wr_s <= 1'b1; wr_q <= 1'b1;
      rd_meta <= 1'b1; rd_s <= 1'b1;
      adr_l   <= '0;
      dat_l   <= '0;
    end else begin
      cs_meta <= nCS; cs_s <= cs_meta; cs_q <= cs_s;
      wr_meta <= nWR; wr_s <= wr_meta; wr_q <= wr_s;
      rd_meta <= nRD; rd_s <= rd_meta;
      if (!cs_s && !wr_s) begin
        adr_l <= dsp_adr;
        dat_l <= dsp_dat_i;
      end
    end
  end

  // Write event: synchronised nWR rising edge while the chip was selected.
  assign wr_off = adr_l - BASE_ADDR;
  assign wr_idx = wr_off[IDX_W-1:0];
  assign wr_hit = wr_s && !wr_q && !cs_q && (adr_l >= BASE_ADDR) && (wr_off < TOTAL_D);

  always_comb begin
    mask_set = mask;
    stg_next = staging;
    if (wr_hit) begin
      mask_set[wr_idx] = 1'b1;
      stg_next[wr_idx] = dat_l;
    end
    mask_next = mask_set;
    commit    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_hit && (wr_off >= DSP_ADR_W'(c * WORDS_PER_CH)) &&
          (wr_off < DSP_ADR_W'((c + 1) * WORDS_PER_CH)) &&
          (&mask_set[c*WORDS_PER_CH +: WORDS_PER_CH])) begin
        commit[c]                                  = 1'b1;
        mask_next[c*WORDS_PER_CH +: WORDS_PER_CH] = '0;
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      for (int i = 0; i < TOTAL; i++) begin
        staging[i] <= RESET_VAL;
        active[i]  <= RESET_VAL;
      end
      mask    <= '0;
      upd     <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < TOTAL; i++) begin
        staging[i] <= stg_next[i];
      end
      mask <= mask_next;
      upd  <= commit;
      for (int c = 0; c < NUM_CH; c++) begin
        pending[c] <= |mask_next[c*WORDS_PER_CH +: WORDS_PER_CH];
        if (commit[c]) begin
          for (int w = 0; w < WORDS_PER_CH; w++) begin
            active[c*WORDS_PER_CH + w] <= stg_next[c*WORDS_PER_CH + w];
          end
        end
      end
    end
  end

  assign rd_off = dsp_adr - BASE_ADDR;
  assign rd_idx = rd_off[IDX_W-1:0];
  assign rd_hit = !cs_s && !rd_s && (dsp_adr >= BASE_ADDR) && (rd_off < TOTAL_D);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      dsp_dat_oe <= 1'b0;
      dsp_dat_o  <= '0;
    end else begin
      dsp_dat_oe <= rd_hit;
      dsp_dat_o  <= rd_hit ? staging[rd_idx] : '0;
    end
  end

  // Registered read of active words, so a commit in the same cycle is not yet visible.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ACK_O <= 1'b0;
      DAT_O <= '0;
    end else if (CYC_I && STB_I && !ACK_O) begin
      ACK_O <= 1'b1;
      if (!WE_I) begin
        if (ADR_I < TOTAL_W)       DAT_O <= 32'(active[ADR_I[IDX_W-1:0]]);
        else if (ADR_I == TOTAL_W) DAT_O <= 32'(pending);
        else                       DAT_O <= '0;
      end
    end else begin
      ACK_O <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_param_bank.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_dsp_param_bank : directed self-checking bench for dsp_param_bank. Rev 1.0
//------------------------------------------------------------------------------
module tb_dsp_param_bank;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        nCS, nWR, nRD;
  logic [15:0] dsp_adr, dsp_dat_i;
  logic [15:0] dsp_dat_o;
  logic        dsp_dat_oe;
  logic        CYC_I, STB_I, WE_I;
  logic [7:0]  ADR_I;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic [3:0]  upd, pending;

  int checks = 0;
  int errors = 0;

  dsp_param_bank dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .nCS(nCS), .nWR(nWR), .nRD(nRD),
    .dsp_adr(dsp_adr), .dsp_dat_i(dsp_dat_i),
    .dsp_dat_o(dsp_dat_o), .dsp_dat_oe(dsp_dat_oe),
    .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I),
    .DAT_O(DAT_O), .ACK_O(ACK_O),
    .upd(upd), .pending(pending)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // upd is sampled 2, 3 and 4 cycles after the nWR rise; the pulse belongs at 3.
  task automatic dsp_write(input logic [15:0] a, input logic [15:0] d,
                           output logic [3:0] u2, output logic [3:0] u3, output logic [3:0] u4);
    @(negedge CLK_I);
    dsp_adr = a; dsp_dat_i = d; nCS = 1'b0; nWR = 1'b0;
    repeat (4) @(negedge CLK_I);
    nWR = 1'b1;
    repeat (2) @(negedge CLK_I);
    u2 = upd;
    @(negedge CLK_I);
    u3 = upd;
    @(negedge CLK_I);
    u4 = upd;
    nCS = 1'b1;
    repeat (3) @(negedge CLK_I);
  endtask

  task automatic dsp_read(input logic [15:0] a, output logic oe, output logic [15:0] d);
    @(negedge CLK_I);
    dsp_adr = a; nCS = 1'b0; nRD = 1'b0;
    repeat (4) @(negedge CLK_I);
    oe = dsp_dat_oe;
    d  = dsp_dat_o;
    nCS = 1'b1; nRD = 1'b1;
    repeat (3) @(negedge CLK_I);
  endtask

  task automatic wb_xfer(input logic we, input logic [7:0] a, output logic ack, output logic [31:0] d);
    @(negedge CLK_I);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = a;
    @(negedge CLK_I);
    ack = ACK_O;
    d   = DAT_O;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    @(negedge CLK_I);
  endtask

  logic [3:0]  u2, u3, u4, pat;
  logic        ack, oe;
  logic [31:0] d;
  logic [15:0] rd;

  initial begin
    RST_I = 1'b0; nCS = 1'b1; nWR = 1'b1; nRD = 1'b1;
    dsp_adr = '0; dsp_dat_i = '0;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = '0;
    repeat (3) @(negedge CLK_I);
    check("rst_upd", 32'(upd), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_ack", 32'(ACK_O), 32'h0);
    check("rst_dat", DAT_O, 32'h0);
    check("rst_oe", 32'(dsp_dat_oe), 32'h0);
    check("rst_dsp_dat", 32'(dsp_dat_o), 32'h0);
    RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);

    for (int i = 0; i <= 8; i++) begin
      wb_xfer(1'b0, 8'(i), ack, d);
      check($sformatf("rst_wb_ack%0d", i), 32'(ack), 32'h1);
      check($sformatf("rst_wb_dat%0d", i), d, 32'h0);
    end

    // Channel 0 complete write
    dsp_write(16'h400A, 16'h1234, u2, u3, u4);
    check("c0w0_upd", 32'({u2, u3, u4}), 32'h0);
    check("c0w0_pending", 32'(pending), 32'h1);
    dsp_write(16'h400B, 16'hABCD, u2, u3, u4);
    check("c0w1_upd_early", 32'(u2), 32'h0);
    check("c0w1_upd_pulse", 32'(u3), 32'h1);
    check("c0w1_upd_after", 32'(u4), 32'h0);
    check("c0w1_pending", 32'(pending), 32'h0);
    wb_xfer(1'b0, 8'd0, ack, d);
    check("wb_a0", d, 32'h1234);
    wb_xfer(1'b0, 8'd1, ack, d);
    check("wb_a1", d, 32'hABCD);

    dsp_read(16'h400A, oe, rd);
    check("dsprd_oe", 32'(oe), 32'h1);
    check("dsprd_dat", 32'(rd), 32'h1234);
    dsp_read(16'h4020, oe, rd);
    check("dsprd_oor_oe", 32'(oe), 32'h0);
    check("dsprd_pending", 32'(pending), 32'h0);

    // Interleaved channels with a rewrite
    dsp_write(16'h400C, 16'h1111, u2, u3, u4);
    check("c1w0_upd", 32'({u2, u3, u4}), 32'h0);
    dsp_write(16'h4010, 16'h2222, u2, u3, u4);
    check("c3w0_upd", 32'({u2, u3, u4}), 32'h0);
    dsp_write(16'h400C, 16'h3333, u2, u3, u4);
    check("c1w0_rewrite_upd", 32'({u2, u3, u4}), 32'h0);
    check("c1w0_rewrite_pending", 32'(pending), 32'hA);
    dsp_write(16'h400D, 16'h4444, u2, u3, u4);
    check("c1w1_upd_early", 32'(u2), 32'h0);
    check("c1w1_upd_pulse", 32'(u3), 32'h2);
    check("c1w1_upd_after", 32'(u4), 32'h0);
    check("c1w1_pending", 32'(pending), 32'h8);
    wb_xfer(1'b0, 8'd2, ack, d);
    check("wb_a2", d, 32'h3333);
    wb_xfer(1'b0, 8'd3, ack, d);
    check("wb_a3", d, 32'h4444);
    wb_xfer(1'b0, 8'd6, ack, d);
    check("wb_a6_uncommitted", d, 32'h0);
    wb_xfer(1'b0, 8'd0, ack, d);
    check("wb_a0_kept", d, 32'h1234);
    wb_xfer(1'b0, 8'd8, ack, d);
    check("wb_status", d, 32'h8);

    // Wishbone write is acknowledged and ignored
    wb_xfer(1'b1, 8'd2, ack, d);
    check("wb_we_ack", 32'(ack), 32'h1);
    wb_xfer(1'b0, 8'd2, ack, d);
    check("wb_we_nochange", d, 32'h3333);

    // Held strobe: one ACK every other cycle
    @(negedge CLK_I);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 8'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_I);
      pat[i] = ACK_O;
    end
    CYC_I = 1'b0; STB_I = 1'b0;
    @(negedge CLK_I);
    check("wb_b2b_ack", 32'(pat), 32'h5);

    // Out-of-range writes
    dsp_write(16'h4009, 16'h5555, u2, u3, u4);
    check("oor_lo_upd", 32'({u2, u3, u4}), 32'h0);
    dsp_write(16'h4012, 16'h5555, u2, u3, u4);
    check("oor_hi_upd", 32'({u2, u3, u4}), 32'h0);
    check("oor_pending", 32'(pending), 32'h8);
    dsp_read(16'h4010, oe, rd);
    check("oor_staging_c3", 32'(rd), 32'h2222);
    dsp_read(16'h4012, oe, rd);
    check("oor_read_oe", 32'(oe), 32'h0);
    wb_xfer(1'b0, 8'd9, ack, d);
    check("wb_a9_zero", d, 32'h0);

    // Reset in the middle of a channel
    dsp_write(16'h400E, 16'h7777, u2, u3, u4);
    check("c2w0_pending", 32'(pending), 32'hC);
    @(negedge CLK_I);
    RST_I = 1'b0;
    repeat (2) @(negedge CLK_I);
    check("midrst_pending", 32'(pending), 32'h0);
    RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    dsp_write(16'h400F, 16'h8888, u2, u3, u4);
    check("postrst_upd", 32'({u2, u3, u4}), 32'h0);
    check("postrst_pending", 32'(pending), 32'h4);
    wb_xfer(1'b0, 8'd4, ack, d);
    check("postrst_a4", d, 32'h0);
    wb_xfer(1'b0, 8'd5, ack, d);
    check("postrst_a5", d, 32'h0);
    wb_xfer(1'b0, 8'd0, ack, d);
    check("postrst_a0", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dsp_param_bank.md
Name: dsp_param_bank

Overview:
- Parametrised successor to the single-divisor update detector.
- Presents a window of DSP-writable parameter words, split into NUM_CH channels of WORDS_PER_CH words each, to the external asynchronous DSP bus (nCS/nWR/nRD).
- Writes go to a staging copy. When every word of a channel has been written, the channel is committed atomically to its active copy and a one-cycle per-channel update pulse is emitted for downstream blocks such as clock_divisor.
- Active words and a pending status word are readable over a Wishbone slave port.

Parameters:
- DATA_W, 16, DSP data width and width of each parameter word.
- DSP_ADR_W, 16, DSP address width.
- BASE_ADDR, 'h400A, DSP address of channel 0, word 0.
- NUM_CH, 4, number of channels (1..16).
- WORDS_PER_CH, 2, words per channel (1..8).
- RESET_VAL, 'h0000, reset value of every staging and active word.
- WB_ADR_W, 8, Wishbone word-address width.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  asynchronous, active-low reset.
- nCS  in  1  DSP chip select, active low, asynchronous to CLK_I.
- nWR  in  1  DSP write strobe, active low, asynchronous.
- nRD  in  1  DSP read strobe, active low, asynchronous.
- dsp_adr  in  DSP_ADR_W  DSP address.
- dsp_dat_i  in  DATA_W  DSP write data.
- dsp_dat_o  out  DATA_W  DSP read data.
- dsp_dat_oe  out  1  tristate enable for the DSP data bus (top level drives the pad).
- CYC_I  in  1  Wishbone cycle.
- STB_I  in  1  Wishbone strobe.
- WE_I  in  1  Wishbone write enable; writes are acknowledged and ignored.
- ADR_I  in  WB_ADR_W  Wishbone word address.
- DAT_O  out  32  Wishbone read data.
- ACK_O  out  1  Wishbone acknowledge.
- upd  out  NUM_CH  per-channel commit pulse.
- pending  out  NUM_CH  per-channel "partially written" flag.

Behaviour:
- Reset (RST_I=0, asynchronous):
  - All staging and active words = RESET_VAL.
  - Written masks cleared.
  - upd=0, pending=0, ACK_O=0, DAT_O=0, dsp_dat_oe=0, dsp_dat_o=0.
  - Synchroniser flops set to 1 (strobes inactive).
- Synchronisation:
  - nCS, nWR and nRD each pass through a 2-flop synchroniser to give cs_s, wr_s, rd_s.
  - While cs_s=0 and wr_s=0, dsp_adr and dsp_dat_i are registered every cycle into adr_l and dat_l.
- Write event:
  - Occurs in the cycle where wr_s rises (previous wr_s=0, now 1) and the previous cs_s=0.
  - Latency: 3 CLK_I cycles after the nWR pin rises.
- Decode:
  - off = adr_l - BASE_ADDR.
  - In range when adr_l >= BASE_ADDR and off < NUM_CH*WORDS_PER_CH.
  - ch = off / WORDS_PER_CH; w = off % WORDS_PER_CH.
  - Out-of-range write events are ignored.
- In-range write event (cycle E):
  - staging[ch][w] <= dat_l.
  - mask[ch][w] <= 1.
  - Rewriting an already-written word overwrites the staging value and leaves the mask unchanged.
- Commit:
  - Triggered when the write at E sets the last zero bit of mask[ch].
  - At E+1: active[ch] holds the staged values, including the word written at E. mask[ch] is cleared and upd[ch]=1 for exactly one cycle.
  - WORDS_PER_CH=1: every write commits.
- pending[ch] = (mask[ch] != 0). It is registered, so it reflects the mask one cycle after the edge.
- Channels are independent: partial masks of other channels are held while another channel is written.
- DSP read:
  - When cs_s=0, rd_s=0 and dsp_adr is in range, dsp_dat_oe=1 and dsp_dat_o = staging word at that address, registered with 1-cycle latency.
  - Otherwise dsp_dat_oe=0.
  - Reads never alter masks.
- Wishbone (classic, single cycle):
  - When CYC_I & STB_I & !ACK_O, ACK_O=1 on the next cycle and 0 the cycle after. One ACK per access; back-to-back accesses give ACK every other cycle.
  - ADR_I < NUM_CH*WORDS_PER_CH: DAT_O = zero-extended active word at index ADR_I.
  - ADR_I == NUM_CH*WORDS_PER_CH: DAT_O = {zeros, pending}.
  - Any other address: DAT_O=0.
  - A read in the commit cycle returns the pre-commit value.
  - WE_I=1: acknowledged, no state change.
- Reset asserted mid-sequence discards partial masks, and no upd is emitted. After reset release, the first write event requires the synchroniser to see a 0→1 transition.
- A glitch on nWR shorter than one CLK_I period may be missed; this is acceptable, and the DSP bus timing guarantees strobes of at least 3 cycles.

Test Plan:
- Reset, then Wishbone read of addr 0..8 → DAT_O=0 everywhere; upd=0, pending=0.
- DSP writes 'h1234@'h400A, then 'hABCD@'h400B → after the first write pending[0]=1, upd=0. Three cycles after the second nWR rise, upd[0] pulses for exactly one cycle and pending[0]=0. WB read addr0='h1234, addr1='hABCD.
- Write 'h1111@'h400C, 'h2222@'h4010, 'h3333@'h400C (rewrite), 'h4444@'h400D → upd[1] pulse only; active ch1 = {'h3333,'h4444}; pending=4'b1000; WB read addr8='h8.
- Write 'h5555 to 'h4009 and to 'h4012 (out of range) → no staging change, no upd, pending unchanged.
- Write 'h7777@'h400E, assert RST_I=0 for 2 cycles, release, write 'h8888@'h400F → pending[2]=1, no upd[2]; active ch2 stays RESET_VAL.
- DSP read of 'h400A after the scenario-2 writes with nCS=0, nRD=0 → dsp_dat_oe=1, dsp_dat_o='h1234. Read of 'h4020 → dsp_dat_oe=0.
